// File: rtl/mplc_wp_pkg.sv
// Shared definitions for the multi-core logic-unit write port:
// FSM state encoding, default word/address widths, and the width
// helper for the optional grant-wait counter.
package mplc_wp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WRITE = 2'd2,
        ST_REL   = 2'd3
    } wp_state_t;

    localparam int MPLC_WP_DATA_W = 2;
    localparam int MPLC_WP_ADDR_W = 1;

    // Bits needed to count from 0 up to and including the timeout value.
    function automatic int wp_cnt_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mplc_wp_fifo.sv
// Pending-write buffer: synchronous FIFO with a first-word-fall-through
// head. Pushes into a full buffer and pops from an empty one are ignored.
module mplc_wp_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; reset discards everything buffered.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mplc_write_port.sv
// Core-side write requester for the shared logic-unit memory. Buffers core
// writes, requests the three-way arbiter, issues a one-cycle write strobe
// once granted, then releases the request for one cycle.
// Optional feature macro: MPLC_WP_TIMEOUT_EN (grant-wait timeout, TO_ERR).
//
// Handshake: a core write is accepted on a rising edge where
// wr_valid && wr_ready; wr_ready depends only on buffer occupancy. The
// arbiter grant is WE && WT sampled on the same edge.
module mplc_write_port
    import mplc_wp_pkg::*;
#(
    parameter int DATA_W     = MPLC_WP_DATA_W,
    parameter int ADDR_W     = MPLC_WP_ADDR_W,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              WE,
    input  logic              WT,
    output logic              MEM_WR,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_DATA,
    output logic              BUSY,
    output logic              TO_ERR,
    output logic [1:0]        dbg_state
);
    localparam int ENT_W = ADDR_W + DATA_W;

    wp_state_t                   state;
    wp_state_t                   next_state;
    logic                        fifo_push;
    logic                        fifo_pop;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [ENT_W-1:0]            fifo_head;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        timeout_fire;
    logic                        we_q;
    logic                        mem_wr_q;
    logic [ADDR_W-1:0]           mem_addr_q;
    logic [DATA_W-1:0]           mem_data_q;

    assign wr_ready  = !fifo_full;
    assign fifo_push = wr_valid && wr_ready;

    mplc_wp_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (fifo_push),
        .push_data ({wr_addr, wr_data}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next-state and pop decision; WT is the only combinational input used.
    always_comb begin
        next_state = state;
        fifo_pop   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) next_state = ST_REQ;
            end
            ST_REQ: begin
                if (WT) begin
                    next_state = ST_WRITE;
                end else if (timeout_fire) begin
                    next_state = ST_REL;
                    fifo_pop   = 1'b1;
                end
            end
            ST_WRITE: begin
                next_state = ST_REL;
                fifo_pop   = 1'b1;
            end
            ST_REL: begin
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Registered outputs decoded from the upcoming state; address/data zero outside a strobe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            we_q       <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            we_q     <= (next_state == ST_REQ) || (next_state == ST_WRITE);
            mem_wr_q <= (next_state == ST_WRITE);
            if (next_state == ST_WRITE) begin
                mem_addr_q <= fifo_head[DATA_W +: ADDR_W];
                mem_data_q <= fifo_head[DATA_W-1:0];
            end else begin
                mem_addr_q <= '0;
                mem_data_q <= '0;
            end
        end
    end

    assign WE        = we_q;
    assign MEM_WR    = mem_wr_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_DATA  = mem_data_q;
    assign BUSY      = (state != ST_IDLE) || (fifo_count != '0);
    assign dbg_state = state;

`ifdef MPLC_WP_TIMEOUT_EN
    localparam int CNT_W = wp_cnt_w(TIMEOUT);

    logic [CNT_W-1:0] to_cnt;
    logic             to_err_q;

    // The counter would reach TIMEOUT on this edge: give up on the head entry.
    assign timeout_fire = (state == ST_REQ) && !WT && (to_cnt == CNT_W'(TIMEOUT - 1));

    // Grant-wait counter: counts edges spent in REQ, clears on leaving REQ.
    always_ff @(posedge CLK) begin
        if (RST)                                                to_cnt <= '0;
        else if (state == ST_REQ && next_state == ST_REQ)       to_cnt <= to_cnt + 1'b1;
        else                                                    to_cnt <= '0;
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RST)               to_err_q <= 1'b0;
        else if (timeout_fire) to_err_q <= 1'b1;
    end

    assign TO_ERR = to_err_q;
`else
    assign timeout_fire = 1'b0;
    assign TO_ERR       = 1'b0;
`endif

endmodule

// File: tb/tb_mplc_write_port.sv
// Bench for mplc_write_port: three instances share a fixed-priority
// arbiter model; instance 0 can instead take its token from the bench.
module tb_mplc_write_port;
  import mplc_wp_pkg::*;

  localparam int DW = 2;
  localparam int AW = 1;

  // clock / reset
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic [2:0]         wr_valid = '0;
  logic [2:0][AW-1:0] wr_addr  = '0;
  logic [2:0][DW-1:0] wr_data  = '0;
  logic [2:0]         wr_ready;
  logic [2:0]         we;
  logic [2:0]         wt;
  logic [2:0]         mem_wr;
  logic [2:0][AW-1:0] mem_addr;
  logic [2:0][DW-1:0] mem_data;
  logic [2:0]         busy;
  logic [2:0]         to_err;
  logic [2:0][1:0]    dbg_state;

  logic arb_mode = 1'b0;
  logic wt_drv   = 1'b1;

  // fixed-priority arbiter: instance 0 highest
  assign wt[0] = arb_mode ? we[0] : wt_drv;
  assign wt[1] = we[1] & ~we[0];
  assign wt[2] = we[2] & ~we[0] & ~we[1];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mplc_write_port #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(4), .TIMEOUT(15)) u_dut (
      .CLK       (CLK),
      .RST       (RST),
      .wr_valid  (wr_valid[g]),
      .wr_addr   (wr_addr[g]),
      .wr_data   (wr_data[g]),
      .wr_ready  (wr_ready[g]),
      .WE        (we[g]),
      .WT        (wt[g]),
      .MEM_WR    (mem_wr[g]),
      .MEM_ADDR  (mem_addr[g]),
      .MEM_DATA  (mem_data[g]),
      .BUSY      (busy[g]),
      .TO_ERR    (to_err[g]),
      .dbg_state (dbg_state[g])
    );
  end

  int tests_run = 0;
  int tests_failed = 0;
  logic [AW+DW-1:0] exp_q[$];

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    wr_valid = '0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic push0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_valid[0] = 1'b1;
    wr_addr[0] = a;
    wr_data[0] = d;
    tick();
    wr_valid[0] = 1'b0;
  endtask

  task automatic test_reset();
    arb_mode = 1'b0;
    wt_drv = 1'b1;
    apply_reset();
    tick();
    tests_run++; if (we[0] !== 1'b0) begin tests_failed++; $display("FAIL reset_we: got %0b expected 0", we[0]); end
    tests_run++; if (mem_wr[0] !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_wr: got %0b expected 0", mem_wr[0]); end
    tests_run++; if ({mem_addr[0], mem_data[0]} !== 3'b000) begin tests_failed++; $display("FAIL reset_addr_data: got %0h expected 0", {mem_addr[0], mem_data[0]}); end
    tests_run++; if (to_err[0] !== 1'b0) begin tests_failed++; $display("FAIL reset_to_err: got %0b expected 0", to_err[0]); end
    tests_run++; if (busy[0] !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b expected 0", busy[0]); end
    tests_run++; if (wr_ready[0] !== 1'b1) begin tests_failed++; $display("FAIL reset_wr_ready: got %0b expected 1", wr_ready[0]); end
    tests_run++; if (dbg_state[0] !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", dbg_state[0]); end
  endtask

  task automatic test_single();
    wt_drv = 1'b1;
    push0(1'b0, 2'b10);                       // edge t
    tests_run++; if (we[0] !== 1'b0) begin tests_failed++; $display("FAIL single_we_t: got %0b expected 0", we[0]); end
    tests_run++; if (busy[0] !== 1'b1) begin tests_failed++; $display("FAIL single_busy_t: got %0b expected 1", busy[0]); end
    tick();                                   // t+1
    tests_run++; if ({we[0], mem_wr[0]} !== 2'b10) begin tests_failed++; $display("FAIL single_t1: got we/mem_wr %b expected 10", {we[0], mem_wr[0]}); end
    tick();                                   // t+2
    tests_run++; if (mem_wr[0] !== 1'b1) begin tests_failed++; $display("FAIL single_mem_wr_t2: got %0b expected 1", mem_wr[0]); end
    tests_run++; if ({mem_addr[0], mem_data[0]} !== 3'b010) begin tests_failed++; $display("FAIL single_addr_data: got %b expected 010", {mem_addr[0], mem_data[0]}); end
    tick();                                   // t+3
    tests_run++; if ({we[0], mem_wr[0], mem_data[0]} !== 4'b0000) begin tests_failed++; $display("FAIL single_t3: got we/mem_wr/data %b expected 0000", {we[0], mem_wr[0], mem_data[0]}); end
    tick();                                   // t+4
    tests_run++; if ({dbg_state[0], busy[0]} !== 3'b000) begin tests_failed++; $display("FAIL single_t4_idle: got state/busy %b expected 000", {dbg_state[0], busy[0]}); end
  endtask

  task automatic test_contention();
    int req_cycles = 0;
    int wr_cnt = 0;
    int wr_cycle = -1;
    logic [AW+DW-1:0] seen = '0;
    wt_drv = 1'b0;
    push0(1'b1, 2'b01);                       // edge t
    for (int i = 1; i <= 12; i++) begin
      tick();                                 // now in cycle t+i
      if (we[0] && !mem_wr[0]) req_cycles++;
      if (mem_wr[0]) begin wr_cnt++; wr_cycle = i; seen = {mem_addr[0], mem_data[0]}; end
      if (i == 6) wt_drv = 1'b1;              // WT was 0 during t+1..t+5
    end
    tests_run++; if (req_cycles !== 6) begin tests_failed++; $display("FAIL contention_req_cycles: got %0d expected 6", req_cycles); end
    tests_run++; if (wr_cnt !== 1) begin tests_failed++; $display("FAIL contention_wr_count: got %0d expected 1", wr_cnt); end
    tests_run++; if (wr_cycle !== 7) begin tests_failed++; $display("FAIL contention_wr_cycle: got %0d expected 7", wr_cycle); end
    tests_run++; if (seen !== 3'b101) begin tests_failed++; $display("FAIL contention_addr_data: got %b expected 101", seen); end
  endtask

  task automatic test_full();
    logic [4:0] rdy;
    int cnt = 0;
    int last = 0;
    logic [AW+DW-1:0] got;
    logic [AW+DW-1:0] exp;
    wt_drv = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 5; k++) begin
      wr_valid[0] = 1'b1;
      wr_addr[0] = AW'(k % 2);
      wr_data[0] = DW'(k + 1);
      if (k < 4) exp_q.push_back({AW'(k % 2), DW'(k + 1)});
      rdy[k] = wr_ready[0];
      tick();
    end
    wr_valid[0] = 1'b0;
    tests_run++; if (rdy !== 5'b01111) begin tests_failed++; $display("FAIL full_ready_seq: got %b expected 01111", rdy); end
    tests_run++; if (wr_ready[0] !== 1'b0) begin tests_failed++; $display("FAIL full_ready_after: got %0b expected 0", wr_ready[0]); end
    wt_drv = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (mem_wr[0]) begin
        cnt++;
        got = {mem_addr[0], mem_data[0]};
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++; $display("FAIL full_extra_write: got %b expected none", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin tests_failed++; $display("FAIL full_order: got %b expected %b", got, exp); end
        end
        if (cnt > 1) begin
          tests_run++; if (i - last !== 4) begin tests_failed++; $display("FAIL full_spacing: got %0d expected 4", i - last); end
        end
        last = i;
      end
    end
    tests_run++; if (cnt !== 4) begin tests_failed++; $display("FAIL full_write_count: got %0d expected 4", cnt); end
    tests_run++; if (busy[0] !== 1'b0) begin tests_failed++; $display("FAIL full_drained_busy: got %0b expected 0", busy[0]); end
  endtask

  task automatic test_reset_mid_write();
    int waited = 0;
    int after = 0;
    wt_drv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wr_valid[0] = 1'b1;
      wr_addr[0] = AW'(k % 2);
      wr_data[0] = DW'(k);
      tick();
    end
    wr_valid[0] = 1'b0;
    tick();
    wt_drv = 1'b1;
    while (!mem_wr[0] && waited < 10) begin tick(); waited++; end
    tests_run++; if (mem_wr[0] !== 1'b1) begin tests_failed++; $display("FAIL rstw_reach_write: got %0b expected 1", mem_wr[0]); end
    RST = 1'b1;
    tick();
    tests_run++; if ({mem_wr[0], we[0], busy[0]} !== 3'b000) begin tests_failed++; $display("FAIL rstw_outputs: got mem_wr/we/busy %b expected 000", {mem_wr[0], we[0], busy[0]}); end
    tests_run++; if ({mem_addr[0], mem_data[0], dbg_state[0]} !== 5'b0) begin tests_failed++; $display("FAIL rstw_addr_data_state: got %b expected 00000", {mem_addr[0], mem_data[0], dbg_state[0]}); end
    RST = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); if (mem_wr[0]) after++; end
    tests_run++; if (after !== 0) begin tests_failed++; $display("FAIL rstw_no_writes: got %0d expected 0", after); end
  endtask

  task automatic test_three_way();
    int cnt [3] = '{0, 0, 0};
    int overlap = 0;
    arb_mode = 1'b1;
    for (int g = 0; g < 3; g++) begin
      wr_valid[g] = 1'b1;
      wr_addr[g] = AW'(g % 2);
      wr_data[g] = DW'(g + 1);
    end
    tick();
    wr_valid = '0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if ((32'(mem_wr[0]) + 32'(mem_wr[1]) + 32'(mem_wr[2])) > 1) overlap++;
      for (int g = 0; g < 3; g++) if (mem_wr[g]) cnt[g]++;
    end
    for (int g = 0; g < 3; g++) begin
      tests_run++; if (cnt[g] !== 1) begin tests_failed++; $display("FAIL arb_count_%0d: got %0d expected 1", g, cnt[g]); end
    end
    tests_run++; if (overlap !== 0) begin tests_failed++; $display("FAIL arb_overlap: got %0d expected 0", overlap); end
    arb_mode = 1'b0;
  endtask

  task automatic test_timeout();
    int early = 0;
    int we_low = 0;
    int wr_cnt = 0;
    wt_drv = 1'b0;
    push0(1'b1, 2'b11);                       // edge t
    tick();                                   // REQ cycle 1
`ifdef MPLC_WP_TIMEOUT_EN
    for (int i = 1; i <= 15; i++) begin
      if (to_err[0]) early++;
      if (!we[0]) we_low++;
      if (mem_wr[0]) wr_cnt++;
      tick();
    end                                       // now cycle 16 after REQ entry
    tests_run++; if (early !== 0) begin tests_failed++; $display("FAIL to_early: got %0d expected 0", early); end
    tests_run++; if (we_low !== 0) begin tests_failed++; $display("FAIL to_we_held: got %0d low cycles expected 0", we_low); end
    tests_run++; if ({to_err[0], we[0]} !== 2'b10) begin tests_failed++; $display("FAIL to_rise: got to_err/we %b expected 10", {to_err[0], we[0]}); end
    for (int i = 0; i < 6; i++) begin if (mem_wr[0]) wr_cnt++; tick(); end
    tests_run++; if (wr_cnt !== 0) begin tests_failed++; $display("FAIL to_no_write: got %0d expected 0", wr_cnt); end
    tests_run++; if ({to_err[0], busy[0]} !== 2'b10) begin tests_failed++; $display("FAIL to_sticky_dropped: got to_err/busy %b expected 10", {to_err[0], busy[0]}); end
`else
    for (int i = 0; i < 40; i++) begin
      if (to_err[0]) early++;
      if (!we[0]) we_low++;
      if (mem_wr[0]) wr_cnt++;
      tick();
    end
    tests_run++; if (early !== 0) begin tests_failed++; $display("FAIL noto_to_err: got %0d high cycles expected 0", early); end
    tests_run++; if (we_low !== 0) begin tests_failed++; $display("FAIL noto_we_held: got %0d low cycles expected 0", we_low); end
    tests_run++; if (wr_cnt !== 0) begin tests_failed++; $display("FAIL noto_no_write: got %0d expected 0", wr_cnt); end
    tests_run++; if (dbg_state[0] !== 2'd1) begin tests_failed++; $display("FAIL noto_state_req: got %0d expected 1", dbg_state[0]); end
`endif
    apply_reset();
    tick();
    tests_run++; if ({to_err[0], we[0], busy[0]} !== 3'b000) begin tests_failed++; $display("FAIL to_cleared_by_reset: got %b expected 000", {to_err[0], we[0], busy[0]}); end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_single();
    test_contention();
    test_full();
    test_reset_mid_write();
    test_three_way();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
